// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit:
// opcodes, state encoding, ALU operation codes and ALU operand selects.
package multicycle_control_pkg;

  localparam logic [6:0] OPC_R_TYPE       = 7'b0110011;
  localparam logic [6:0] OPC_I_TYPE_LOGIC = 7'b0010011;
  localparam logic [6:0] OPC_LOAD         = 7'b0000011;
  localparam logic [6:0] OPC_STORE        = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH       = 7'b1100011;
  localparam logic [6:0] OPC_JAL          = 7'b1101111;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_EXEC_I    = 4'd7,
    ST_ALU_WB    = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JAL       = 4'd10,
    ST_TRAP      = 4'd11
  } state_t;

  localparam logic [2:0] ALU_OP_RTYPE  = 3'b000;
  localparam logic [2:0] ALU_OP_ILOGIC = 3'b001;
  localparam logic [2:0] ALU_OP_ADD    = 3'b010;
  localparam logic [2:0] ALU_OP_BRANCH = 3'b011;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  // States that hold a memory request open until the memory answers
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
  endfunction

endpackage

// File: rtl/control_wait_timer.sv
// Memory-wait watchdog. Loaded with MEM_TIMEOUT on clear and counted down
// once per waiting cycle; expired flags the waiting cycle that would make
// the elapsed wait reach MEM_TIMEOUT. MEM_TIMEOUT = 0 disables it.
module control_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_TIMEOUT);

  logic [CW-1:0] remain;

  // Down-counter: reload on clear, decrement while waiting, stop at zero
  always_ff @(posedge clk) begin
    if (clear) begin
      remain <= LOAD_VAL;
    end else if (enable && (remain != '0)) begin
      remain <= remain - 1'b1;
    end
  end

  assign expired = (MEM_TIMEOUT > 0) && enable && (remain == CW'(1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control FSM driving the datapath muxes and enables.
// Optional retired-instruction counter: define MULTICYCLE_CONTROL_PERF_CNT_EN.
//
// state     | meaning
// FETCH     | read instruction at PC, load IR and PC+4 on ready
// DECODE    | compute branch target, dispatch on opcode
// MEM_ADDR  | compute load/store address rs1+imm
// MEM_READ  | data read, wait for ready
// MEM_WB    | write loaded data to register file
// MEM_WRITE | data write, wait for ready
// EXEC_R    | ALU rs1 op rs2
// EXEC_I    | ALU rs1 op imm
// ALU_WB    | write ALU result to register file
// BRANCH    | compare rs1/rs2, conditional PC update
// JAL       | PC jump and link write
// TRAP      | illegal opcode or memory timeout, held until reset
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALU_OP_WIDTH = 3,
  parameter int MEM_TIMEOUT  = 15
`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
  , parameter int CNT_WIDTH  = 32
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              OP_i,
  input  logic                    Mem_Ready_i,
  output logic                    PC_Write_o,
  output logic                    IR_Write_o,
  output logic                    I_or_D_o,
  output logic                    Mem_Read_o,
  output logic                    Mem_Write_o,
  output logic                    Mem_to_Reg_o,
  output logic                    Reg_Write_o,
  output logic [1:0]              ALU_Src_A_o,
  output logic [1:0]              ALU_Src_B_o,
  output logic [ALU_OP_WIDTH-1:0] ALU_Op_o,
  output logic                    Branch_o,
  output logic                    Illegal_o,
  output logic                    Timeout_o,
  output logic [3:0]              State_o
`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
  , output logic [CNT_WIDTH-1:0]  Instr_Count_o
`endif
);

  state_t state_q, state_d;
  logic   illegal_q, timeout_q;
  logic   illegal_set;
  logic   wait_en, wait_clear, wait_expired;
  logic   pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write, branch;
  logic [1:0] src_a, src_b;
  logic [2:0] alu_op;

  assign wait_en    = is_wait_state(state_q) && !Mem_Ready_i;
  assign wait_clear = reset || (state_d != state_q);

  control_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .clear   (wait_clear),
    .enable  (wait_en),
    .expired (wait_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Sticky trap cause flags
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (illegal_set)  illegal_q <= 1'b1;
      if (wait_expired) timeout_q <= 1'b1;
    end
  end

  // Next-state logic; a ready in the expiry cycle takes priority over the trap
  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (Mem_Ready_i)       state_d = ST_DECODE;
        else if (wait_expired) state_d = ST_TRAP;
      end
      ST_DECODE: begin
        case (OP_i)
          OPC_LOAD, OPC_STORE: state_d = ST_MEM_ADDR;
          OPC_R_TYPE:          state_d = ST_EXEC_R;
          OPC_I_TYPE_LOGIC:    state_d = ST_EXEC_I;
          OPC_BRANCH:          state_d = ST_BRANCH;
          OPC_JAL:             state_d = ST_JAL;
          default: begin
            state_d     = ST_TRAP;
            illegal_set = 1'b1;
          end
        endcase
      end
      ST_MEM_ADDR: state_d = (OP_i == OPC_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ: begin
        if (Mem_Ready_i)       state_d = ST_MEM_WB;
        else if (wait_expired) state_d = ST_TRAP;
      end
      ST_MEM_WRITE: begin
        if (Mem_Ready_i)       state_d = ST_FETCH;
        else if (wait_expired) state_d = ST_TRAP;
      end
      ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JAL: state_d = ST_FETCH;
      ST_EXEC_R, ST_EXEC_I:                     state_d = ST_ALU_WB;
      ST_TRAP:                                  state_d = ST_TRAP;
      default:                                  state_d = ST_FETCH;
    endcase
  end

  // Output decode; everything is forced low while reset is asserted
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    src_a      = SRC_A_PC;
    src_b      = SRC_B_RS2;
    alu_op     = ALU_OP_RTYPE;
    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        if (Mem_Ready_i) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          src_a    = SRC_A_PC;
          src_b    = SRC_B_FOUR;
          alu_op   = ALU_OP_ADD;
        end
      end
      ST_DECODE: begin
        src_a  = SRC_A_OLD_PC;
        src_b  = SRC_B_IMM;
        alu_op = ALU_OP_ADD;
      end
      ST_MEM_ADDR: begin
        src_a  = SRC_A_RS1;
        src_b  = SRC_B_IMM;
        alu_op = ALU_OP_ADD;
      end
      ST_MEM_READ: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      ST_EXEC_R: begin
        src_a  = SRC_A_RS1;
        src_b  = SRC_B_RS2;
        alu_op = ALU_OP_RTYPE;
      end
      ST_EXEC_I: begin
        src_a  = SRC_A_RS1;
        src_b  = SRC_B_IMM;
        alu_op = ALU_OP_ILOGIC;
      end
      ST_ALU_WB: reg_write = 1'b1;
      ST_BRANCH: begin
        src_a  = SRC_A_RS1;
        src_b  = SRC_B_RS2;
        alu_op = ALU_OP_BRANCH;
        branch = 1'b1;
      end
      ST_JAL: begin
        pc_write  = 1'b1;
        reg_write = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      branch     = 1'b0;
      src_a      = 2'b00;
      src_b      = 2'b00;
      alu_op     = 3'b000;
    end
  end

  assign PC_Write_o   = pc_write;
  assign IR_Write_o   = ir_write;
  assign I_or_D_o     = i_or_d;
  assign Mem_Read_o   = mem_read;
  assign Mem_Write_o  = mem_write;
  assign Mem_to_Reg_o = mem_to_reg;
  assign Reg_Write_o  = reg_write;
  assign ALU_Src_A_o  = src_a;
  assign ALU_Src_B_o  = src_b;
  assign ALU_Op_o     = ALU_OP_WIDTH'(alu_op);
  assign Branch_o     = branch;
  assign Illegal_o    = illegal_q & ~reset;
  assign Timeout_o    = timeout_q & ~reset;
  assign State_o      = reset ? 4'd0 : state_q;

`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] instr_cnt_q;
  logic                 instr_done;

  assign instr_done = (state_q == ST_ALU_WB) || (state_q == ST_MEM_WB) ||
                      (state_q == ST_BRANCH) || (state_q == ST_JAL) ||
                      ((state_q == ST_MEM_WRITE) && Mem_Ready_i);

  // Retired-instruction counter, bumped on the last cycle of each instruction
  always_ff @(posedge clk) begin
    if (reset)           instr_cnt_q <= '0;
    else if (instr_done) instr_cnt_q <= instr_cnt_q + 1'b1;
  end

  assign Instr_Count_o = instr_cnt_q;
`endif

endmodule
